sales_total_clear_ctrl: RTL and testbench
=========================================

// Module: sales_total_clear_ctrl
// PURPOSE
//  Multi-channel vending sales accumulator with a confirmed clear sequence.
//  - Sums per-channel sale prices into a running total.
//  - On a two-step clear (request, then confirm within a window), publishes the
//    final total as a one-cycle snapshot and restarts the running total from zero.
//  - Sits between the per-slot dispense logic and the operator/audit display.
// PARAMETERS
//  N_CH        4   number of product channels (>=1)
//  PRICE_W     8   width of one channel's sale price
//  TOTAL_W     16  width of running total and snapshot (>= PRICE_W+$clog2(N_CH))
//  CONFIRM_CYC 16  clear-confirm window in cycles (>=1)
// PORTS
//  clk            in  1              system clock, all logic on rising edge
//  reset          in  1              synchronous, active-high
//  sale_valid     in  N_CH           one-cycle sale event per channel
//  sale_price     in  N_CH*PRICE_W   channel i price at [i*PRICE_W +: PRICE_W]
//  clear_req      in  1              operator clear request (level sampled)
//  clear_confirm  in  1              operator confirm (level sampled)
//  running_total  out TOTAL_W        current accumulated total
//  cleared_total  out TOTAL_W        snapshot of total at clear; held until next clear
//  cleared_valid  out 1              one-cycle pulse when cleared_total updates
//  clear_armed    out 1              high while waiting for confirm
//  overflow       out 1              sticky wrap/saturate indicator (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, window counter 0.
//  - Accumulation: cycle_sum = sum of sale_price[i] over channels with sale_valid[i]=1.
//    - cycle_sum is computed at PRICE_W+$clog2(N_CH) bits with no loss.
//    - running_total <= running_total + cycle_sum; visible the next cycle (1-cycle latency).
//  - FSM:
//    - IDLE  -> ARMED when clear_req=1. Window counter loads CONFIRM_CYC-1.
//    - ARMED -> DUMP when clear_confirm=1.
//    - ARMED -> IDLE when the counter reaches 0 with no confirm (timeout; no clear).
//    - ARMED: counter decrements every cycle; clear_armed=1 only in this state.
//    - DUMP  -> IDLE unconditionally after 1 cycle.
//  - DUMP cycle:
//    - cleared_total <= running_total + cycle_sum, i.e. sales in the DUMP cycle
//      belong to the closing period.
//    - running_total <= 0; cleared_valid=1 the following cycle only.
//    - overflow is cleared.
//  - Sales continue to accumulate in IDLE and ARMED; none are ever dropped.
//  - clear_req while ARMED or in DUMP: ignored (no window restart).
//  - clear_confirm in IDLE: ignored.
//  - Confirm and timeout in the same cycle: confirm wins.
//  - Reset asserted mid-sequence: FSM returns to IDLE and all registers zero;
//    reset has priority over every other input.
// CONFIGURATION
//  - Macro SALES_TOTAL_SAT_EN:
//    - defined: addition saturates at 2^TOTAL_W-1; overflow sets when a clamp occurs.
//    - undefined: addition wraps modulo 2^TOTAL_W; overflow sets on carry-out.
//  - overflow is sticky in both modes; it clears only on reset or DUMP.
// STRUCTURE
//  - Package sales_pkg:
//    - clear_state_t enum {IDLE, ARMED, DUMP};
//    - default width constants PRICE_W_DEF, TOTAL_W_DEF.
//  - Sub-module sales_adder_tree: combinational N_CH-input masked price summer
//    producing cycle_sum; top holds FSM, counter, total and snapshot registers.
// TESTING
//  1. Reset, then channel 0 sale of 25 and channel 2 sale of 10 in the same cycle
//     -> running_total=35 the next cycle; overflow=0.
//  2. Total=100; clear_req, confirm 3 cycles later; a sale of 5 in the DUMP cycle
//     -> cleared_total=105, cleared_valid pulses once, running_total=0 afterwards.
//  3. clear_req, no confirm for CONFIRM_CYC cycles -> clear_armed drops, state IDLE,
//     total unchanged, no cleared_valid pulse.
//  4. TOTAL_W=8, total=250, sale of 10:
//     - SAT_EN -> total=255, overflow=1;
//     - no SAT_EN -> total=4, overflow=1.
//  5. reset pulsed while ARMED with total=77 -> next cycle all outputs 0,
//     a later confirm is ignored.
//  6. All N_CH channels sell 255 in one cycle (PRICE_W=8, N_CH=4)
//     -> running_total increases by 1020 exactly.

Source files
------------

// File: rtl/sales_pkg.sv
// Shared types and default widths for the vending sales total/clear controller.
package sales_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DUMP  = 2'd2
    } clear_state_t;

    localparam int unsigned PRICE_W_DEF = 8;
    localparam int unsigned TOTAL_W_DEF = 16;

endpackage

// File: rtl/sales_adder_tree.sv
// Combinational masked summer: adds every channel price whose sale_valid bit
// is set. The result is wide enough that the sum of all channels at full price
// cannot lose bits.
module sales_adder_tree
    import sales_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned PRICE_W = PRICE_W_DEF,
    parameter int unsigned SUM_W   = PRICE_W + $clog2(N_CH)
)
(
    input  logic [N_CH-1:0]         sale_valid,
    input  logic [N_CH*PRICE_W-1:0] sale_price,
    output logic [SUM_W-1:0]        cycle_sum
);

    // Sum the prices of all channels reporting a sale this cycle.
    always_comb begin
        cycle_sum = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sale_valid[i]) begin
                cycle_sum = cycle_sum + SUM_W'(sale_price[i*PRICE_W +: PRICE_W]);
            end
        end
    end

endmodule

// File: rtl/sales_total_clear_ctrl.sv
// Multi-channel vending sales accumulator with a two-step (request + confirm)
// clear sequence that publishes a one-cycle snapshot of the closing total.
// Optional macro SALES_TOTAL_SAT_EN: when defined the running total saturates
// at all-ones instead of wrapping; overflow flags the clamp / carry-out.
module sales_total_clear_ctrl
    import sales_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned PRICE_W     = PRICE_W_DEF,
    parameter int unsigned TOTAL_W     = TOTAL_W_DEF,
    parameter int unsigned CONFIRM_CYC = 16
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         sale_valid,
    input  logic [N_CH*PRICE_W-1:0] sale_price,
    input  logic                    clear_req,
    input  logic                    clear_confirm,
    output logic [TOTAL_W-1:0]      running_total,
    output logic [TOTAL_W-1:0]      cleared_total,
    output logic                    cleared_valid,
    output logic                    clear_armed,
    output logic                    overflow
);

    localparam int unsigned SUM_W = PRICE_W + $clog2(N_CH);
    localparam int unsigned CNT_W = (CONFIRM_CYC > 1) ? $clog2(CONFIRM_CYC) : 1;

    clear_state_t       state;
    clear_state_t       next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [SUM_W-1:0]   cycle_sum;
    logic [TOTAL_W:0]   wide_sum;
    logic [TOTAL_W-1:0] add_result;
    logic               add_carry;

    sales_adder_tree #(
        .N_CH    (N_CH),
        .PRICE_W (PRICE_W),
        .SUM_W   (SUM_W)
    ) u_adder (
        .sale_valid (sale_valid),
        .sale_price (sale_price),
        .cycle_sum  (cycle_sum)
    );

    // Add this cycle's sales to the running total, wrapping or clamping.
    always_comb begin
        wide_sum  = {1'b0, running_total} + (TOTAL_W+1)'(cycle_sum);
        add_carry = wide_sum[TOTAL_W];
`ifdef SALES_TOTAL_SAT_EN
        add_result = add_carry ? '1 : wide_sum[TOTAL_W-1:0];
`else
        add_result = wide_sum[TOTAL_W-1:0];
`endif
    end

    // Clear-sequence next state and confirm-window counter.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    next_state = ARMED;
                    cnt_next   = CNT_W'(CONFIRM_CYC - 1);
                end
            end
            ARMED: begin
                // Confirm takes precedence over an expiring window.
                if (clear_confirm) begin
                    next_state = DUMP;
                end else if (cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DUMP: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register and confirm-window counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Running total, snapshot, snapshot strobe and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_total <= '0;
            cleared_total <= '0;
            cleared_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            cleared_valid <= (state == DUMP);
            if (state == DUMP) begin
                // Sales landing in the dump cycle close out the old period.
                cleared_total <= add_result;
                running_total <= '0;
                overflow      <= 1'b0;
            end else begin
                running_total <= add_result;
                if (add_carry) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign clear_armed = (state == ARMED);

endmodule

// File: tb/tb_sales_total_clear_ctrl.sv
// Directed self-checking bench for sales_total_clear_ctrl. A second instance
// with an 8-bit total exercises wrap/saturate behaviour.
module tb_sales_total_clear_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sale_valid;
    logic [31:0] sale_price;
    logic        clear_req;
    logic        clear_confirm;
    logic [15:0] running_total;
    logic [15:0] cleared_total;
    logic        cleared_valid;
    logic        clear_armed;
    logic        overflow;

    logic [0:0]  sv8;
    logic [7:0]  sp8;
    logic        cr8;
    logic        cc8;
    logic [7:0]  rt8;
    logic [7:0]  ct8;
    logic        cv8;
    logic        ca8;
    logic        ov8;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    sales_total_clear_ctrl #(
        .N_CH        (4),
        .PRICE_W     (8),
        .TOTAL_W     (16),
        .CONFIRM_CYC (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sale_valid    (sale_valid),
        .sale_price    (sale_price),
        .clear_req     (clear_req),
        .clear_confirm (clear_confirm),
        .running_total (running_total),
        .cleared_total (cleared_total),
        .cleared_valid (cleared_valid),
        .clear_armed   (clear_armed),
        .overflow      (overflow)
    );

    sales_total_clear_ctrl #(
        .N_CH        (1),
        .PRICE_W     (8),
        .TOTAL_W     (8),
        .CONFIRM_CYC (2)
    ) dut8 (
        .clk           (clk),
        .reset         (reset),
        .sale_valid    (sv8),
        .sale_price    (sp8),
        .clear_req     (cr8),
        .clear_confirm (cc8),
        .running_total (rt8),
        .cleared_total (ct8),
        .cleared_valid (cv8),
        .clear_armed   (ca8),
        .overflow      (ov8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sale_valid = '0; sale_price = '0; clear_req = 1'b0; clear_confirm = 1'b0;
        sv8 = '0; sp8 = '0; cr8 = 1'b0; cc8 = 1'b0;
        tick(); tick();
        check("rst_running", 32'(running_total), 0);
        check("rst_cleared", 32'(cleared_total), 0);
        check("rst_cvalid", 32'(cleared_valid), 0);
        check("rst_armed", 32'(clear_armed), 0);
        check("rst_overflow", 32'(overflow), 0);
        reset = 1'b0;

        // Channel 0 sells 25, channel 2 sells 10; channel 1 price present but not valid.
        sale_price = {8'd7, 8'd10, 8'd99, 8'd25};
        sale_valid = 4'b0101;
        tick();
        sale_valid = 4'b0000;
        check("t1_total", 32'(running_total), 35);
        check("t1_overflow", 32'(overflow), 0);

        // Bring total to 100, then clear with a sale of 5 in the dump cycle.
        sale_price = {8'd0, 8'd0, 8'd65, 8'd0};
        sale_valid = 4'b0010;
        tick();
        sale_valid = 4'b0000;
        check("t2_total100", 32'(running_total), 100);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t2_armed", 32'(clear_armed), 1);
        tick(); tick();
        clear_confirm = 1'b1;
        tick();
        clear_confirm = 1'b0;
        check("t2_dump_armed", 32'(clear_armed), 0);
        check("t2_dump_cvalid", 32'(cleared_valid), 0);
        sale_price = {8'd5, 8'd0, 8'd0, 8'd0};
        sale_valid = 4'b1000;
        tick();
        sale_valid = 4'b0000;
        check("t2_cleared", 32'(cleared_total), 105);
        check("t2_cvalid", 32'(cleared_valid), 1);
        check("t2_running0", 32'(running_total), 0);
        tick();
        check("t2_cvalid_once", 32'(cleared_valid), 0);
        check("t2_cleared_hold", 32'(cleared_total), 105);
        check("t2_running_hold", 32'(running_total), 0);

        // Timeout: request held into the window must not restart it.
        sale_price = {8'd0, 8'd0, 8'd0, 8'd42};
        sale_valid = 4'b0001;
        tick();
        sale_valid = 4'b0000;
        check("t3_total42", 32'(running_total), 42);
        pulses = 0;
        clear_req = 1'b1;
        tick();
        if (cleared_valid) pulses++;
        check("t3_armed", 32'(clear_armed), 1);
        tick();
        if (cleared_valid) pulses++;
        tick();
        if (cleared_valid) pulses++;
        clear_req = 1'b0;
        tick();
        if (cleared_valid) pulses++;
        check("t3_armed_last", 32'(clear_armed), 1);
        tick();
        if (cleared_valid) pulses++;
        check("t3_timeout", 32'(clear_armed), 0);
        // Confirm while idle must be ignored.
        clear_confirm = 1'b1;
        tick();
        if (cleared_valid) pulses++;
        tick();
        if (cleared_valid) pulses++;
        clear_confirm = 1'b0;
        check("t3_idle_confirm_armed", 32'(clear_armed), 0);
        check("t3_pulses", 32'(pulses), 0);
        check("t3_total_kept", 32'(running_total), 42);
        check("t3_cleared_kept", 32'(cleared_total), 105);

        // Reset while armed with total 77.
        sale_price = {8'd0, 8'd0, 8'd0, 8'd35};
        sale_valid = 4'b0001;
        tick();
        sale_valid = 4'b0000;
        check("t5_total77", 32'(running_total), 77);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("t5_armed", 32'(clear_armed), 1);
        reset = 1'b1;
        clear_confirm = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_running", 32'(running_total), 0);
        check("t5_cleared", 32'(cleared_total), 0);
        check("t5_cvalid", 32'(cleared_valid), 0);
        check("t5_armed0", 32'(clear_armed), 0);
        check("t5_overflow", 32'(overflow), 0);
        tick(); tick();
        clear_confirm = 1'b0;
        check("t5_late_confirm_cvalid", 32'(cleared_valid), 0);
        check("t5_late_confirm_armed", 32'(clear_armed), 0);

        // All channels at full price in one cycle.
        sale_price = {8'd255, 8'd255, 8'd255, 8'd255};
        sale_valid = 4'b1111;
        tick();
        sale_valid = 4'b0000;
        check("t6_total1020", 32'(running_total), 1020);
        check("t6_overflow", 32'(overflow), 0);

        // Confirm in the final window cycle beats the timeout.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick(); tick(); tick();
        check("t7_armed_cnt0", 32'(clear_armed), 1);
        clear_confirm = 1'b1;
        tick();
        clear_confirm = 1'b0;
        check("t7_dump_armed", 32'(clear_armed), 0);
        tick();
        check("t7_cvalid", 32'(cleared_valid), 1);
        check("t7_cleared", 32'(cleared_total), 1020);
        check("t7_running0", 32'(running_total), 0);

        // 8-bit total: 250 + 10.
        sp8 = 8'd250; sv8 = 1'b1;
        tick();
        check("t4_total250", 32'(rt8), 250);
        check("t4_ov0", 32'(ov8), 0);
        sp8 = 8'd10;
        tick();
        sp8 = 8'd1;
`ifdef SALES_TOTAL_SAT_EN
        check("t4_sat_total", 32'(rt8), 255);
`else
        check("t4_wrap_total", 32'(rt8), 4);
`endif
        check("t4_ov1", 32'(ov8), 1);
        tick();
        sv8 = 1'b0;
`ifdef SALES_TOTAL_SAT_EN
        check("t4_sat_hold", 32'(rt8), 255);
`else
        check("t4_wrap_next", 32'(rt8), 5);
`endif
        check("t4_ov_sticky", 32'(ov8), 1);
        cr8 = 1'b1;
        tick();
        cr8 = 1'b0;
        cc8 = 1'b1;
        tick();
        cc8 = 1'b0;
        tick();
        check("t4_cvalid", 32'(cv8), 1);
        check("t4_ov_cleared", 32'(ov8), 0);
        check("t4_running0", 32'(rt8), 0);
`ifdef SALES_TOTAL_SAT_EN
        check("t4_cleared", 32'(ct8), 255);
`else
        check("t4_cleared", 32'(ct8), 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
